manual_mem_loader: RTL and testbench

- Front-panel data-entry block: the write side of the data memory the CPU reads.
- Debounces a push button and samples a 4-bit switch nibble per press. Assembles four nibbles, MSB nibble first, into a 16-bit word.
- Writes the word into data memory at an auto-incrementing address.
- Sits beside the CPU on the data-memory port. Top-level muxes d_we/d_addr/d_dataout from this block while load_en=1; the CPU is held.

---
 rtl/manual_mem_loader.sv | 117 +++++++++++
 tb/tb_manual_mem_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/manual_mem_loader.sv
// Front-panel data loader: debounced button, four-nibble word assembly,
// and auto-incrementing writes into data memory.
module manual_mem_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 5000,
    parameter int unsigned ADDR_W          = 8,
    parameter int unsigned DATA_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic              button,
    input  logic [3:0]        nibble,
    output logic              d_we,
    output logic [ADDR_W-1:0] d_addr,
    output logic [DATA_W-1:0] d_dataout,
    output logic [DATA_W-1:0] entry,
    output logic [1:0]        nib_cnt,
    output logic              active
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, ADVANCE} state_t;

    state_t            state, next_state;
    logic              sync1, sync2, stable, press;
    logic [CNT_W-1:0]  db_cnt;
    logic [ADDR_W-1:0] addr_ptr, addr_n;
    logic [DATA_W-1:0] entry_n, dout_n;
    logic [1:0]        nib_cnt_n;

    // Level is accepted only after DEBOUNCE_CYCLES consecutive mismatching cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_LAST) begin
                stable <= sync2;
                db_cnt <= '0;
                press  <= sync2;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        entry_n    = entry;
        nib_cnt_n  = nib_cnt;
        dout_n     = d_dataout;
        addr_n     = addr_ptr;
        case (state)
            IDLE: begin
                entry_n   = '0;
                nib_cnt_n = '0;
                if (load_en) next_state = COLLECT;
            end
            COLLECT: begin
                if (!load_en) begin
                    next_state = IDLE;
                    entry_n    = '0;
                    nib_cnt_n  = '0;
                end else if (press) begin
                    if (nib_cnt != 2'd3) begin
                        entry_n   = {entry[DATA_W-5:0], nibble};
                        nib_cnt_n = nib_cnt + 2'd1;
                    end else begin
                        dout_n     = {entry[DATA_W-5:0], nibble};
                        next_state = WRITE;
                    end
                end
            end
            WRITE: next_state = ADVANCE;
            ADVANCE: begin
                addr_n     = addr_ptr + ADDR_W'(1);
                entry_n    = '0;
                nib_cnt_n  = '0;
                next_state = load_en ? COLLECT : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            entry     <= '0;
            nib_cnt   <= '0;
            d_dataout <= '0;
            addr_ptr  <= '0;
            d_we      <= 1'b0;
        end else begin
            state     <= next_state;
            entry     <= entry_n;
            nib_cnt   <= nib_cnt_n;
            d_dataout <= dout_n;
            addr_ptr  <= addr_n;
            d_we      <= (next_state == WRITE);
        end
    end

    // Write address only moves in ADVANCE, so it is stable through WRITE
    assign d_addr = addr_ptr;
    assign active = (state != IDLE);

endmodule

// File: tb/tb_manual_mem_loader.sv
// Scoreboard bench for manual_mem_loader with a short debounce window.
module tb_manual_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic        button;
    logic [3:0]  nibble;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [15:0] d_dataout;
    logic [15:0] entry;
    logic [1:0]  nib_cnt;
    logic        active;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    logic prev_we = 1'b0;

    manual_mem_loader #(.DEBOUNCE_CYCLES(4), .ADDR_W(8), .DATA_W(16)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .button(button),
        .nibble(nibble), .d_we(d_we), .d_addr(d_addr), .d_dataout(d_dataout),
        .entry(entry), .nib_cnt(nib_cnt), .active(active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next queued expectation
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (d_we === 1'b1) begin
                if (prev_we) begin
                    checks++;
                    errors++;
                    $display("FAIL we_pulse actual=2+cycles expected=1 cycle");
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write addr=%0h data=%0h expected=none", d_addr, d_dataout);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", {24'd0, d_addr}, {24'd0, e.addr});
                    chk("wr_data", {16'd0, d_dataout}, {16'd0, e.data});
                end
            end
            prev_we = d_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] v);
        nibble = v;
        button = 1'b1;
        cyc(8);
        button = 1'b0;
        cyc(8);
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Raise the button for the 4th nibble and return during the WRITE cycle
    task automatic press_until_write(input logic [3:0] v, output logic seen);
        seen   = 1'b0;
        nibble = v;
        button = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (d_we === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL write_timeout actual=no d_we expected=d_we within 20 cycles");
        end
    endtask

    initial begin
        logic seen;
        logic [7:0] exp_addr;
        reset   = 1'b0;
        load_en = 1'b0;
        button  = 1'b0;
        nibble  = 4'h0;
        cyc(3);
        chk("rst_we", {31'd0, d_we}, 32'd0);
        chk("rst_addr", {24'd0, d_addr}, 32'd0);
        chk("rst_dout", {16'd0, d_dataout}, 32'd0);
        chk("rst_entry", {16'd0, entry}, 32'd0);
        chk("rst_nib", {30'd0, nib_cnt}, 32'd0);
        chk("rst_active", {31'd0, active}, 32'd0);
        reset = 1'b1;
        cyc(2);

        // Basic word 1234 at address 00
        load_en = 1'b1;
        cyc(2);
        chk("active_on", {31'd0, active}, 32'd1);
        press(4'h1);
        chk("entry_1", {16'd0, entry}, 32'h0001);
        chk("nib_1", {30'd0, nib_cnt}, 32'd1);
        press(4'h2);
        chk("entry_2", {16'd0, entry}, 32'h0012);
        press(4'h3);
        chk("entry_3", {16'd0, entry}, 32'h0123);
        chk("nib_3", {30'd0, nib_cnt}, 32'd3);
        expect_wr(8'h00, 16'h1234);
        press(4'h4);
        chk("addr_after", {24'd0, d_addr}, 32'h01);
        chk("nib_after", {30'd0, nib_cnt}, 32'd0);
        chk("entry_after", {16'd0, entry}, 32'd0);
        chk("dout_hold", {16'd0, d_dataout}, 32'h1234);

        // Bouncy press counts once; short pulse is rejected
        nibble = 4'h5;
        button = 1'b1; cyc(1);
        button = 1'b0; cyc(1);
        button = 1'b1; cyc(1);
        button = 1'b0; cyc(1);
        button = 1'b1; cyc(10);
        button = 1'b0; cyc(8);
        chk("bounce_nib", {30'd0, nib_cnt}, 32'd1);
        chk("bounce_entry", {16'd0, entry}, 32'h0005);
        nibble = 4'h9;
        button = 1'b1; cyc(3);
        button = 1'b0; cyc(8);
        chk("glitch_nib", {30'd0, nib_cnt}, 32'd1);
        press(4'h6);
        press(4'h7);
        expect_wr(8'h01, 16'h5678);
        press(4'h8);

        // Fill to the top of the address space, then wrap to 00
        exp_addr = 8'h02;
        for (int w = 0; w < 255; w++) begin
            expect_wr(exp_addr, 16'hFFFF);
            exp_addr = exp_addr + 8'd1;
            for (int n = 0; n < 4; n++) press(4'hF);
        end
        chk("wrap_addr", {24'd0, d_addr}, 32'h01);

        // Abort a partial word, then resume at the same address
        press(4'hA);
        press(4'hB);
        chk("abort_nib", {30'd0, nib_cnt}, 32'd2);
        chk("abort_entry", {16'd0, entry}, 32'h00AB);
        load_en = 1'b0;
        cyc(2);
        chk("abort_active", {31'd0, active}, 32'd0);
        chk("abort_entry0", {16'd0, entry}, 32'd0);
        chk("abort_nib0", {30'd0, nib_cnt}, 32'd0);
        chk("abort_addr", {24'd0, d_addr}, 32'h01);
        load_en = 1'b1;
        cyc(2);
        press(4'hC);
        press(4'hD);
        press(4'hE);
        expect_wr(8'h01, 16'hCDEF);
        press(4'hF);

        // load_en drops during WRITE: write completes, pointer advances
        press(4'h9);
        press(4'h8);
        press(4'h7);
        expect_wr(8'h02, 16'h9876);
        press_until_write(4'h6, seen);
        load_en = 1'b0;
        cyc(3);
        chk("we_drop_active", {31'd0, active}, 32'd0);
        chk("we_drop_addr", {24'd0, d_addr}, 32'h03);
        button = 1'b0;
        cyc(8);
        chk("release_idle", {31'd0, active}, 32'd0);

        // Reset asserted in WRITE clears everything immediately
        load_en = 1'b1;
        cyc(2);
        press(4'h4);
        press(4'h3);
        press(4'h2);
        press_until_write(4'h1, seen);
        reset = 1'b0;
        #1;
        chk("rw_we", {31'd0, d_we}, 32'd0);
        chk("rw_addr", {24'd0, d_addr}, 32'd0);
        chk("rw_entry", {16'd0, entry}, 32'd0);
        chk("rw_nib", {30'd0, nib_cnt}, 32'd0);
        button = 1'b0;
        cyc(10);
        reset = 1'b1;
        cyc(2);
        press(4'h2);
        press(4'h4);
        press(4'h6);
        expect_wr(8'h00, 16'h2468);
        press(4'h8);
        cyc(4);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
